// File: rtl/perceptron_vote_filter.sv
`default_nettype none
// ============================================================================
//  Module   : perceptron_vote_filter
//  Brief    : Majority-vote filter over fixed windows of the perceptron's
//             1-bit classification stream; one decision and done per window.
//  Revision : 1.0 - initial release
// ============================================================================
module perceptron_vote_filter #(
    parameter int WINDOW = 16,
    parameter int THRESH = 8,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             class_in,
    input  logic             class_valid,
    input  logic             start,
    input  logic             cont,
    output logic             decision,
    output logic [CNT_W-1:0] ones_count,
    output logic             done,
    output logic             busy
);

    localparam logic [1:0]       c_st_idle    = 2'd0;
    localparam logic [1:0]       c_st_collect = 2'd1;
    localparam logic [1:0]       c_st_report  = 2'd2;
    localparam logic [CNT_W-1:0] c_last_idx   = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] c_thresh     = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] c_one        = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_sample_cnt;
    logic [CNT_W-1:0] r_ones_acc;
    logic [CNT_W-1:0] r_ones_count;
    logic             r_decision;
    logic [CNT_W-1:0] w_final_ones;
    logic             w_accept;
    logic             w_last;
    logic             w_clear;

    assign w_accept     = (r_state == c_st_collect) && class_valid;
    assign w_last       = w_accept && (r_sample_cnt == c_last_idx);
    // Includes the sample arriving this cycle so the last one is counted.
    assign w_final_ones = r_ones_acc + {{(CNT_W-1){1'b0}}, class_in};
    assign w_clear      = (r_state != c_st_collect) && (w_next_state == c_st_collect);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:    if (start)  w_next_state = c_st_collect;
            c_st_collect: if (w_last) w_next_state = c_st_report;
            c_st_report:  w_next_state = (cont || start) ? c_st_collect : c_st_idle;
            default:      w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample_cnt <= '0;
            r_ones_acc   <= '0;
            r_ones_count <= '0;
            r_decision   <= 1'b0;
        end else begin
            if (w_clear) begin
                r_sample_cnt <= '0;
                r_ones_acc   <= '0;
            end else if (w_accept) begin
                r_sample_cnt <= r_sample_cnt + c_one;
                r_ones_acc   <= w_final_ones;
            end
            if (w_last) begin
                r_ones_count <= w_final_ones;
                r_decision   <= (w_final_ones > c_thresh);
            end
        end
    end

    assign decision   = r_decision;
    assign ones_count = r_ones_count;
    assign done       = (r_state == c_st_report);
    assign busy       = (r_state == c_st_collect);

endmodule
`default_nettype wire

// File: tb/tb_perceptron_vote_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_perceptron_vote_filter
//  Brief    : Directed/randomised bench for perceptron_vote_filter with a
//             window-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_perceptron_vote_filter;

    localparam int WINDOW = 16;
    localparam int THRESH = 8;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             class_in;
    logic             class_valid;
    logic             start;
    logic             cont;
    logic             decision;
    logic [CNT_W-1:0] ones_count;
    logic             done;
    logic             busy;

    perceptron_vote_filter #(
        .WINDOW (WINDOW),
        .THRESH (THRESH),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .class_in    (class_in),
        .class_valid (class_valid),
        .start       (start),
        .cont        (cont),
        .decision    (decision),
        .ones_count  (ones_count),
        .done        (done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model: collecting flag, list of accepted samples, report flag.
    bit m_active;
    bit m_report;
    int m_win[$];
    int m_count;
    bit m_dec;
    int m_windows;

    int base;
    int last_done;
    int steps;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s observed=timeout expected=completion", tag);
    endtask

    function automatic void model_reset();
        m_active = 1'b0;
        m_report = 1'b0;
        m_win.delete();
        m_count  = 0;
        m_dec    = 1'b0;
    endfunction

    function automatic void model_edge();
        int s;
        s = 0;
        if (rst) begin
            model_reset();
        end else if (m_report) begin
            m_report = 1'b0;
            if (cont || start) begin
                m_active = 1'b1;
                m_win.delete();
            end
        end else if (m_active) begin
            if (class_valid) begin
                m_win.push_back(int'(class_in));
                if (m_win.size() == WINDOW) begin
                    foreach (m_win[i]) s += m_win[i];
                    m_count  = s;
                    m_dec    = (s > THRESH);
                    m_active = 1'b0;
                    m_report = 1'b1;
                    m_windows++;
                end
            end
        end else if (start) begin
            m_active = 1'b1;
            m_win.delete();
        end
    endfunction

    task automatic check_all();
        check_bit("done", done, m_report);
        check_bit("busy", busy, m_active);
        check_bit("decision", decision, m_dec);
        check_cnt("ones_count", ones_count, CNT_W'(m_count));
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run_window(input logic [WINDOW-1:0] bits, input bit gapped);
        int sent;
        int guard;
        sent  = 0;
        guard = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        while (sent < WINDOW && guard < 400) begin
            class_valid = gapped ? ($urandom_range(0, 4) < 2) : 1'b1;
            class_in    = class_valid ? bits[sent] : 1'($urandom);
            start       = gapped && (sent == WINDOW / 2);
            if (class_valid) sent++;
            step();
            guard++;
        end
        class_valid = 1'b0;
        class_in    = 1'b0;
        start       = 1'b0;
        if (sent < WINDOW) timeout("window_samples");
    endtask

    initial begin
        rst         = 1'b1;
        class_in    = 1'b0;
        class_valid = 1'b0;
        start       = 1'b0;
        cont        = 1'b0;
        m_windows   = 0;
        model_reset();

        // Reset state
        step();
        step();
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_cnt("rst_count", ones_count, '0);
        #2 rst = 1'b0;

        // 12 ones then 4 zeros, contiguous
        run_window(16'h0FFF, 1'b0);
        check_bit("t1_done", done, 1'b1);
        check_cnt("t1_count", ones_count, 8'd12);
        check_bit("t1_dec", decision, 1'b1);
        check_bit("t1_busy", busy, 1'b0);
        step();
        check_bit("t1_done_drop", done, 1'b0);

        // Tie at threshold, then one above
        run_window(16'h00FF, 1'b0);
        check_cnt("tie_count", ones_count, 8'd8);
        check_bit("tie_dec", decision, 1'b0);
        step();
        run_window(16'h01FF, 1'b0);
        check_cnt("above_count", ones_count, 8'd9);
        check_bit("above_dec", decision, 1'b1);
        step();

        // Gapped valid with start pulsed mid-window
        run_window(16'h0FFF, 1'b1);
        check_bit("gap_done", done, 1'b1);
        check_cnt("gap_count", ones_count, 8'd12);
        check_bit("gap_dec", decision, 1'b1);
        step();

        // Continuous mode; second window all zeros
        cont      = 1'b1;
        start     = 1'b1;
        step();
        start       = 1'b0;
        class_valid = 1'b1;
        base        = m_windows;
        last_done   = -1;
        steps       = 0;
        while (m_windows < base + 3 && steps < 200) begin
            class_in = (m_windows == base + 1) ? 1'b0 : 1'($urandom);
            step();
            steps++;
            if (done === 1'b1) begin
                if (last_done >= 0) check_int("done_spacing", cyc - last_done, 17);
                last_done = cyc;
            end
            if (m_report && m_windows == base + 2) begin
                check_cnt("zero_count", ones_count, 8'd0);
                check_bit("zero_dec", decision, 1'b0);
            end
        end
        if (m_windows < base + 3) timeout("cont_windows");
        cont        = 1'b0;
        class_valid = 1'b0;
        step();
        check_bit("cont_idle_busy", busy, 1'b0);

        // Async reset mid-window after 10 samples
        start = 1'b1;
        step();
        start       = 1'b0;
        class_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            class_in = 1'($urandom);
            step();
        end
        rst = 1'b1;
        #1;
        model_reset();
        check_bit("arst_busy", busy, 1'b0);
        check_bit("arst_done", done, 1'b0);
        check_bit("arst_dec", decision, 1'b0);
        check_cnt("arst_count", ones_count, '0);
        for (int i = 0; i < 8; i++) step();
        #2 rst = 1'b0;
        class_valid = 1'b0;
        step();
        run_window(WINDOW'($urandom), 1'b0);
        step();

        // Valid traffic in IDLE without start
        for (int i = 0; i < 24; i++) begin
            class_valid = 1'($urandom);
            class_in    = 1'($urandom);
            step();
        end
        class_valid = 1'b0;
        check_bit("idle_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
